// File: rtl/vjtag_dr_bridge_pkg.sv
// Shared types and frame field layout for the vJTAG data-register bridge.
// Define VJTAG_DR_BRIDGE_PARITY_EN to add an even-parity bit at the top of the DR frame.
package vjtag_dr_bridge_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } obuf_state_e;

    localparam logic IR_ID   = 1'b0;
    localparam logic IR_DATA = 1'b1;

    // Field positions as offsets above the W payload bits.
    localparam int unsigned WR_OFS   = 0;  // update frame: write strobe
    localparam int unsigned CLR_OFS  = 1;  // update frame: clear status
    localparam int unsigned RSPV_OFS = 0;  // capture frame: rsp_valid
    localparam int unsigned OVF_OFS  = 1;  // capture frame: overflow
    localparam int unsigned FERR_OFS = 2;  // capture frame: frame_err
    localparam int unsigned PAR_OFS  = 3;  // both frames: parity (when enabled)

`ifdef VJTAG_DR_BRIDGE_PARITY_EN
    localparam int unsigned PAR_BITS = 1;
`else
    localparam int unsigned PAR_BITS = 0;
`endif

    function automatic int unsigned frame_len(input int unsigned w);
        return w + 3 + PAR_BITS;
    endfunction

endpackage

// File: rtl/vjtag_dr_bridge_outbuf.sv
// Single-entry valid/ready holding register; flags a write that lands while a word is still held.
module vjtag_dr_bridge_outbuf
    import vjtag_dr_bridge_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_ready,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  ovf_c
);

    obuf_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    // A write accepted alongside a pop replaces the word and keeps the buffer full.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        ovf_c   = 1'b0;
        case (state_q)
            EMPTY: begin
                if (wr_en) begin
                    state_d = FULL;
                    data_d  = wr_data;
                end
            end
            FULL: begin
                if (wr_en && rd_ready) begin
                    data_d = wr_data;
                end else if (wr_en) begin
                    ovf_c = 1'b1;
                end else if (rd_ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign rd_valid = (state_q == FULL);
    assign rd_data  = data_q;

endmodule

// File: rtl/vjtag_dr_bridge.sv
// vJTAG user DR bridge in the tck domain: constant ID register plus a DATA shift frame
// feeding a valid/ready write port and returning response words with sticky status.
// Optional parity bit controlled by VJTAG_DR_BRIDGE_PARITY_EN.
module vjtag_dr_bridge
    import vjtag_dr_bridge_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [31:0] ID_CODE    = 32'h5F1F_0001
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  tdi,
    output logic                  tdo,
    input  logic                  ir_in,
    input  logic                  virtual_state_cdr,
    input  logic                  virtual_state_sdr,
    input  logic                  virtual_state_udr,
    input  logic                  virtual_state_uir,
    output logic                  upd_valid,
    input  logic                  upd_ready,
    output logic [DATA_WIDTH-1:0] upd_data,
    input  logic                  rsp_valid,
    output logic                  rsp_ready,
    input  logic [DATA_WIDTH-1:0] rsp_data
);

    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned L  = frame_len(W);
    localparam int unsigned CW = $clog2(L + 2);
    localparam int unsigned XW = (L > 32) ? L : 32;
    localparam logic [XW-1:0] ID_EXT = XW'(ID_CODE);

    logic [L-1:0]  sr_q, sr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sel_q, sel_d;
    logic          overflow_q, overflow_d;
    logic          frame_err_q, frame_err_d;

    logic [L-1:0]  cap_c;
    logic          par_ok_c;
    logic          upd_data_c;
    logic          frame_ok_c;
    logic          wr_en_c;
    logic          ovf_c;

    // DATA capture frame: {frame_err, overflow, rsp_valid, rsp_data}, LSB first.
    always_comb begin
        cap_c                = '0;
        cap_c[W-1:0]         = rsp_valid ? rsp_data : '0;
        cap_c[W + RSPV_OFS]  = rsp_valid;
        cap_c[W + OVF_OFS]   = overflow_q;
        cap_c[W + FERR_OFS]  = frame_err_q;
`ifdef VJTAG_DR_BRIDGE_PARITY_EN
        cap_c[W + PAR_OFS]   = ^cap_c[L-2:0];
`endif
    end

`ifdef VJTAG_DR_BRIDGE_PARITY_EN
    assign par_ok_c = ~(^sr_q);
`else
    assign par_ok_c = 1'b1;
`endif

    assign upd_data_c = virtual_state_udr && (sel_q == IR_DATA);
    assign frame_ok_c = (cnt_q == CW'(L)) && par_ok_c;
    assign wr_en_c    = upd_data_c && frame_ok_c && sr_q[W + WR_OFS];
    assign rsp_ready  = !reset && virtual_state_cdr && (sel_q == IR_DATA) && rsp_valid;

    // Shift/capture datapath and sticky status; clear first so a same-frame set wins.
    always_comb begin
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        overflow_d  = overflow_q;
        frame_err_d = frame_err_q;

        if (virtual_state_uir) begin
            sel_d = ir_in;
        end

        if (virtual_state_cdr) begin
            sr_d  = (sel_q == IR_DATA) ? cap_c : ID_EXT[L-1:0];
            cnt_d = '0;
        end else if (virtual_state_sdr) begin
            sr_d = {tdi, sr_q[L-1:1]};
            if (cnt_q != CW'(L + 1)) begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (upd_data_c) begin
            if (!frame_ok_c) begin
                frame_err_d = 1'b1;
            end else begin
                if (sr_q[W + CLR_OFS]) begin
                    overflow_d  = 1'b0;
                    frame_err_d = 1'b0;
                end
                if (ovf_c) begin
                    overflow_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sr_q        <= '0;
            cnt_q       <= '0;
            sel_q       <= IR_ID;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign tdo = sr_q[0];

    vjtag_dr_bridge_outbuf #(
        .DATA_WIDTH (W)
    ) u_outbuf (
        .clock    (clock),
        .reset    (reset),
        .wr_en    (wr_en_c),
        .wr_data  (sr_q[W-1:0]),
        .rd_ready (upd_ready),
        .rd_valid (upd_valid),
        .rd_data  (upd_data),
        .ovf_c    (ovf_c)
    );

endmodule

// File: tb/tb_vjtag_dr_bridge.sv
// Directed bench for vjtag_dr_bridge with DATA_WIDTH=8, parity disabled (11-bit frames).
module tb_vjtag_dr_bridge;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       tdi = 1'b0;
    logic       tdo;
    logic       ir_in = 1'b0;
    logic       cdr = 1'b0;
    logic       sdr = 1'b0;
    logic       udr = 1'b0;
    logic       uir = 1'b0;
    logic       upd_valid;
    logic       upd_ready = 1'b0;
    logic [7:0] upd_data;
    logic       rsp_valid = 1'b0;
    logic       rsp_ready;
    logic [7:0] rsp_data = 8'h00;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    logic [15:0] dout;

    vjtag_dr_bridge #(
        .DATA_WIDTH (8),
        .ID_CODE    (32'h5F1F_0001)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .tdi               (tdi),
        .tdo               (tdo),
        .ir_in             (ir_in),
        .virtual_state_cdr (cdr),
        .virtual_state_sdr (sdr),
        .virtual_state_udr (udr),
        .virtual_state_uir (uir),
        .upd_valid         (upd_valid),
        .upd_ready         (upd_ready),
        .upd_data          (upd_data),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_data          (rsp_data)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_ir(input logic v);
        ir_in = v;
        uir   = 1'b1;
        tick();
        uir   = 1'b0;
    endtask

    task automatic capture(input logic exp_rr);
        cdr = 1'b1;
        #1;
        check("rsp_ready_in_cdr", 32'(rsp_ready), 32'(exp_rr));
        tick();
        cdr = 1'b0;
        #1;
        check("rsp_ready_after_cdr", 32'(rsp_ready), 32'd0);
    endtask

    task automatic shift(input logic [15:0] din, input int n, output logic [15:0] dq);
        dq = '0;
        for (int i = 0; i < n; i++) begin
            dq[i] = tdo;
            tdi   = din[i];
            sdr   = 1'b1;
            tick();
        end
        sdr = 1'b0;
        tdi = 1'b0;
    endtask

    task automatic update();
        udr = 1'b1;
        tick();
        udr = 1'b0;
    endtask

    task automatic read_status(input string tag, input logic [10:0] exp);
        logic [15:0] d;
        capture(1'b0);
        shift(16'h0000, 11, d);
        check(tag, 32'(d[10:0]), 32'(exp));
    endtask

    task automatic write_frame(input logic [15:0] din, input int n);
        logic [15:0] d;
        capture(1'b0);
        shift(din, n, d);
        update();
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b0;
        check("reset_tdo", 32'(tdo), 32'd0);
        check("reset_upd_valid", 32'(upd_valid), 32'd0);
        check("reset_upd_data", 32'(upd_data), 32'h00);
        check("reset_rsp_ready", 32'(rsp_ready), 32'd0);

        // ID read; rsp_valid held high must not pop while ID is selected.
        rsp_valid = 1'b1;
        rsp_data  = 8'h3C;
        capture(1'b0);
        rsp_valid = 1'b0;
        rsp_data  = 8'h00;
        check("id_first_tdo", 32'(tdo), 32'd1);
        shift(16'h0000, 11, dout);
        check("id_read", 32'(dout[10:0]), 32'h001);

        // Write A5, hold, then drain.
        set_ir(1'b1);
        capture(1'b0);
        shift(16'h01A5, 11, dout);
        check("wr_pre_upd_valid", 32'(upd_valid), 32'd0);
        update();
        check("wr_upd_valid", 32'(upd_valid), 32'd1);
        check("wr_upd_data", 32'(upd_data), 32'hA5);
        tick();
        tick();
        check("wr_hold_valid", 32'(upd_valid), 32'd1);
        check("wr_hold_data", 32'(upd_data), 32'hA5);
        upd_ready = 1'b1;
        tick();
        upd_ready = 1'b0;
        check("wr_drained", 32'(upd_valid), 32'd0);

        // Overflow then clear.
        write_frame(16'h0111, 11);
        write_frame(16'h0122, 11);
        check("ovf_data_kept", 32'(upd_data), 32'h11);
        check("ovf_valid", 32'(upd_valid), 32'd1);
        read_status("ovf_status", 11'h200);
        capture(1'b0);
        shift(16'h0200, 11, dout);
        check("clr_readout", 32'(dout[10:0]), 32'h200);
        update();
        check("clr_data_kept", 32'(upd_data), 32'h11);
        read_status("clr_status", 11'h000);

        // Response pop.
        upd_ready = 1'b1;
        tick();
        upd_ready = 1'b0;
        rsp_valid = 1'b1;
        rsp_data  = 8'h3C;
        capture(1'b1);
        rsp_valid = 1'b0;
        rsp_data  = 8'h00;
        shift(16'h0000, 11, dout);
        check("rsp_frame", 32'(dout[10:0]), 32'h13C);

        // Short frame, then long (saturated) frame.
        write_frame(16'h01A5, 10);
        check("short_no_valid", 32'(upd_valid), 32'd0);
        read_status("short_ferr", 11'h400);
        write_frame(16'h0200, 11);
        read_status("ferr_cleared", 11'h000);
        write_frame(16'h01A5, 12);
        check("long_no_valid", 32'(upd_valid), 32'd0);
        read_status("long_ferr", 11'h400);
        write_frame(16'h0200, 11);

        // Update coinciding with upd_ready while FULL replaces the word, no overflow.
        write_frame(16'h0111, 11);
        capture(1'b0);
        shift(16'h0122, 11, dout);
        upd_ready = 1'b1;
        update();
        upd_ready = 1'b0;
        check("simul_valid", 32'(upd_valid), 32'd1);
        check("simul_data", 32'(upd_data), 32'h22);
        read_status("simul_no_ovf", 11'h000);

        // Reset while FULL with overflow and frame_err set.
        write_frame(16'h015A, 11);
        write_frame(16'h01A5, 10);
        read_status("pre_reset_status", 11'h600);
        reset = 1'b1;
        tick();
        check("rst_upd_valid", 32'(upd_valid), 32'd0);
        check("rst_upd_data", 32'(upd_data), 32'h00);
        check("rst_tdo", 32'(tdo), 32'd0);
        reset = 1'b0;
        read_status("rst_sel_is_id", 11'h001);
        set_ir(1'b1);
        read_status("rst_status", 11'h000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
